// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   DATA_W       - width of one received character
//   ERR_CNT_MAX  - ceiling of the framing-error counter
//   baud_state_e - states of the mid-bit tick generator
package uart_pkg;

    localparam int DATA_W      = 8;
    localparam int ERR_CNT_MAX = 255;

    typedef enum logic [1:0] {
        B_IDLE = 2'd0,
        B_HALF = 2'd1,
        B_BIT  = 2'd2
    } baud_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO holding received bytes.
// Ports:
//   clk, arst_n        - clock, synchronous active-low reset
//   push, push_data    - write request and byte
//   pop                - read request (ignored while empty)
//   full, empty, level - occupancy status
//   head               - oldest byte, 0 while empty
// A push while full is accepted only if a pop frees a slot in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = DATA_W
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign level   = cnt_q;
    // Storage is not reset, so mask the head while nothing valid is stored.
    assign head    = empty ? '0 : mem_q[rptr_q];

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_ok) wptr_d = wptr_q + PTR_W'(1);
        if (pop_ok)  rptr_d = rptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
            2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Sequencer for the UART receive datapath.
// Ports:
//   clk, arst_n             - clock, synchronous active-low reset
//   enable                  - host receive enable
//   fsm_busy/done/err       - bit-level FSM status
//   fsm_restart             - FSM request to restart baud timing at a start edge
//   rx_byte                 - SIPO byte, valid with fsm_done
//   rx_en, tick             - enable and mid-bit strobe to the FSM
//   rd_valid/rd_data/rd_ready - FWFT read port of the RX FIFO
//   level                   - FIFO occupancy
//   frame_err_cnt, overrun  - host status, cleared by clr_status
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic                          enable,
    input  logic                          fsm_busy,
    input  logic                          fsm_done,
    input  logic                          fsm_err,
    input  logic                          fsm_restart,
    input  logic [DATA_W-1:0]             rx_byte,
    output logic                          rx_en,
    output logic                          tick,
    output logic                          rd_valid,
    output logic [DATA_W-1:0]             rd_data,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic [7:0]                    frame_err_cnt,
    output logic                          overrun,
    input  logic                          clr_status
);

    localparam int BCNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [BCNT_W-1:0] HALF_LAST = BCNT_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(CLKS_PER_BIT - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'(ERR_CNT_MAX)) ? v : v + 8'd1;
    endfunction

    baud_state_e       bstate_q, bstate_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              rx_en_q, rx_en_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              ovr_q, ovr_d;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              drop;

    // Tick is decoded from registered state only.
    assign tick = ((bstate_q == B_HALF) && (bcnt_q == HALF_LAST)) ||
                  ((bstate_q == B_BIT)  && (bcnt_q == BIT_LAST));

    always_comb begin
        bstate_d = bstate_q;
        bcnt_d   = bcnt_q;
        if (fsm_restart) begin
            bstate_d = B_HALF;
            bcnt_d   = '0;
        end else begin
            case (bstate_q)
                B_IDLE: bcnt_d = '0;
                B_HALF: begin
                    if (tick) begin
                        bstate_d = B_BIT;
                        bcnt_d   = '0;
                    end else begin
                        bcnt_d = bcnt_q + BCNT_W'(1);
                    end
                end
                B_BIT: begin
                    if (tick) begin
                        bcnt_d = '0;
                    end else if (!fsm_busy) begin
                        bstate_d = B_IDLE;
                        bcnt_d   = '0;
                    end else begin
                        bcnt_d = bcnt_q + BCNT_W'(1);
                    end
                end
                default: begin
                    bstate_d = B_IDLE;
                    bcnt_d   = '0;
                end
            endcase
        end
    end

    // Once running, a busy FSM keeps the enable alive so the frame completes.
    assign rx_en_d = enable || (rx_en_q && fsm_busy);

    assign pop  = !fifo_empty && rd_ready;
    assign drop = fsm_done && fifo_full && !pop;

    // A same-cycle event wins over the clear.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_status)   err_cnt_d = {7'd0, fsm_err};
        else if (fsm_err) err_cnt_d = sat_inc(err_cnt_q);
    end

    assign ovr_d = (ovr_q && !clr_status) || drop;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            bstate_q  <= B_IDLE;
            bcnt_q    <= '0;
            rx_en_q   <= 1'b0;
            err_cnt_q <= '0;
            ovr_q     <= 1'b0;
        end else begin
            bstate_q  <= bstate_d;
            bcnt_q    <= bcnt_d;
            rx_en_q   <= rx_en_d;
            err_cnt_q <= err_cnt_d;
            ovr_q     <= ovr_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .arst_n    (arst_n),
        .push      (fsm_done),
        .push_data (rx_byte),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level),
        .head      (rd_data)
    );

    assign rd_valid      = !fifo_empty;
    assign rx_en         = rx_en_q;
    assign frame_err_cnt = err_cnt_q;
    assign overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       enable, fsm_busy, fsm_done, fsm_err, fsm_restart;
    logic [7:0] rx_byte;
    logic       rx_en, tick, rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready;
    logic [2:0] level;
    logic [7:0] frame_err_cnt;
    logic       overrun;
    logic       clr_status;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .enable        (enable),
        .fsm_busy      (fsm_busy),
        .fsm_done      (fsm_done),
        .fsm_err       (fsm_err),
        .fsm_restart   (fsm_restart),
        .rx_byte       (rx_byte),
        .rx_en         (rx_en),
        .tick          (tick),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .rd_ready      (rd_ready),
        .level         (level),
        .frame_err_cnt (frame_err_cnt),
        .overrun       (overrun),
        .clr_status    (clr_status)
    );

    typedef struct {
        logic       en, busy, done, err, rdy, clr;
        logic [7:0] b;
        logic       x_en, x_val;
        logic [7:0] x_data;
        logic [2:0] x_lvl;
        logic       x_ovr;
        logic [7:0] x_cnt;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic en, busy, done, err, rdy, clr,
                                input logic [7:0] b,
                                input logic x_en, x_val,
                                input logic [7:0] x_data,
                                input logic [2:0] x_lvl,
                                input logic x_ovr,
                                input logic [7:0] x_cnt);
        vec_t v;
        v.en = en; v.busy = busy; v.done = done; v.err = err; v.rdy = rdy; v.clr = clr;
        v.b = b; v.x_en = x_en; v.x_val = x_val; v.x_data = x_data;
        v.x_lvl = x_lvl; v.x_ovr = x_ovr; v.x_cnt = x_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable = 0; fsm_busy = 0; fsm_done = 0; fsm_err = 0; fsm_restart = 0;
        rx_byte = 8'h00; rd_ready = 0; clr_status = 0;
    endtask

    initial begin
        int first;
        int nt;
        logic [7:0] exp_q [4];

        idle_inputs();
        arst_n = 0;
        cyc(); cyc();
        arst_n = 1;

        // reset state
        chk("rst.rx_en", rx_en, 0);
        chk("rst.tick", tick, 0);
        chk("rst.rd_valid", rd_valid, 0);
        chk("rst.rd_data", rd_data, 0);
        chk("rst.level", level, 0);
        chk("rst.err_cnt", frame_err_cnt, 0);
        chk("rst.overrun", overrun, 0);

        //            en bsy dn er rd cl byte   | en val data  lvl ov cnt
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 8'h00,    0, 0, 8'h00, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 8'h00,    1, 0, 8'h00, 0, 0, 0);
        tbl[2]  = mk(1, 1, 1, 0, 0, 0, 8'hA5,    1, 1, 8'hA5, 1, 0, 0);
        tbl[3]  = mk(1, 1, 1, 0, 0, 0, 8'h3C,    1, 1, 8'hA5, 2, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0, 0, 8'h00,    1, 1, 8'hA5, 2, 0, 0);
        tbl[5]  = mk(0, 1, 0, 0, 1, 0, 8'h00,    1, 1, 8'h3C, 1, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 8'h00,    0, 1, 8'h3C, 1, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 1, 0, 8'h00,    0, 0, 8'h00, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 1, 0, 8'h00,    0, 0, 8'h00, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 1, 0, 0, 8'h00,    0, 0, 8'h00, 0, 0, 1);
        tbl[10] = mk(0, 0, 0, 1, 0, 0, 8'h00,    0, 0, 8'h00, 0, 0, 2);
        tbl[11] = mk(0, 0, 0, 0, 0, 1, 8'h00,    0, 0, 8'h00, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, 1, 0, 1, 8'h00,    0, 0, 8'h00, 0, 0, 1);
        tbl[13] = mk(0, 0, 1, 0, 1, 0, 8'h5A,    0, 1, 8'h5A, 1, 0, 1);
        tbl[14] = mk(0, 0, 1, 0, 1, 0, 8'h6B,    0, 1, 8'h6B, 1, 0, 1);
        tbl[15] = mk(0, 0, 0, 0, 1, 0, 8'h00,    0, 0, 8'h00, 0, 0, 1);

        for (int i = 0; i < 16; i++) begin
            enable = tbl[i].en; fsm_busy = tbl[i].busy; fsm_done = tbl[i].done;
            fsm_err = tbl[i].err; rd_ready = tbl[i].rdy; clr_status = tbl[i].clr;
            rx_byte = tbl[i].b;
            cyc();
            chk($sformatf("v%0d.rx_en", i), rx_en, tbl[i].x_en);
            chk($sformatf("v%0d.rd_valid", i), rd_valid, tbl[i].x_val);
            chk($sformatf("v%0d.rd_data", i), rd_data, tbl[i].x_data);
            chk($sformatf("v%0d.level", i), level, tbl[i].x_lvl);
            chk($sformatf("v%0d.overrun", i), overrun, tbl[i].x_ovr);
            chk($sformatf("v%0d.err_cnt", i), frame_err_cnt, tbl[i].x_cnt);
            chk($sformatf("v%0d.tick", i), tick, 0);
        end
        idle_inputs();

        // overrun: five pushes into a 4-deep FIFO with no reads
        for (int i = 1; i <= 5; i++) begin
            fsm_done = 1; rx_byte = 8'(i);
            cyc();
            chk($sformatf("ovr.level%0d", i), level, (i < 4) ? i : 4);
            chk($sformatf("ovr.flag%0d", i), overrun, (i == 5) ? 1 : 0);
        end
        // clear in the same cycle as a drop keeps the flag
        fsm_done = 1; rx_byte = 8'h77; clr_status = 1;
        cyc();
        fsm_done = 0; clr_status = 0;
        chk("ovr.clr_with_drop", overrun, 1);
        chk("ovr.level_full", level, 4);
        rd_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovr.rd_valid%0d", i), rd_valid, 1);
            chk($sformatf("ovr.rd_data%0d", i), rd_data, i);
            cyc();
        end
        rd_ready = 0;
        chk("ovr.drained_valid", rd_valid, 0);
        chk("ovr.drained_level", level, 0);
        clr_status = 1;
        cyc();
        clr_status = 0;
        chk("ovr.cleared", overrun, 0);

        // full FIFO with simultaneous push and pop
        exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33; exp_q[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            fsm_done = 1; rx_byte = exp_q[i];
            cyc();
        end
        fsm_done = 0;
        chk("fp.level_before", level, 4);
        fsm_done = 1; rx_byte = 8'h55; rd_ready = 1;
        cyc();
        fsm_done = 0; rd_ready = 0;
        chk("fp.overrun", overrun, 0);
        chk("fp.level", level, 4);
        chk("fp.head", rd_data, 8'h22);
        exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44; exp_q[3] = 8'h55;
        rd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fp.rd_data%0d", i), rd_data, exp_q[i]);
            cyc();
        end
        rd_ready = 0;
        chk("fp.empty", rd_valid, 0);

        // error counter saturation and clear-with-error
        clr_status = 1;
        cyc();
        clr_status = 0;
        chk("err.cleared", frame_err_cnt, 0);
        fsm_err = 1;
        repeat (260) cyc();
        fsm_err = 0;
        chk("err.saturated", frame_err_cnt, 255);
        fsm_err = 1; clr_status = 1;
        cyc();
        fsm_err = 0; clr_status = 0;
        chk("err.clr_with_err", frame_err_cnt, 1);
        cyc();
        chk("err.hold", frame_err_cnt, 1);

        // baud timing: restart in cycle 0, busy until cycle 155
        fsm_restart = 1; fsm_busy = 1;
        cyc();
        fsm_restart = 0;
        for (int j = 1; j <= 180; j++) begin
            chk($sformatf("baud.tick@%0d", j), tick,
                (j >= 8 && j <= 152 && ((j - 8) % 16) == 0) ? 1 : 0);
            fsm_busy = (j < 155);
            cyc();
        end
        fsm_busy = 0;

        // reset mid-frame
        enable = 1; fsm_busy = 1; fsm_restart = 1;
        cyc();
        fsm_restart = 0;
        for (int i = 1; i <= 5; i++) begin
            fsm_done = 1; rx_byte = 8'(8'hC0 + i);
            cyc();
        end
        fsm_done = 0;
        fsm_err = 1;
        cyc();
        fsm_err = 0;
        repeat (6) cyc();
        chk("mid.level_pre", level, 4);
        chk("mid.ovr_pre", overrun, 1);
        arst_n = 0;
        cyc();
        arst_n = 1;
        chk("mid.rx_en", rx_en, 0);
        chk("mid.tick", tick, 0);
        chk("mid.rd_valid", rd_valid, 0);
        chk("mid.rd_data", rd_data, 0);
        chk("mid.level", level, 0);
        chk("mid.err_cnt", frame_err_cnt, 0);
        chk("mid.overrun", overrun, 0);
        nt = 0;
        for (int i = 0; i < 40; i++) begin
            if (tick) nt++;
            cyc();
        end
        chk("mid.tick_silent", nt, 0);
        chk("mid.rx_en_back", rx_en, 1);
        fsm_restart = 1;
        cyc();
        fsm_restart = 0;
        first = -1;
        for (int j = 1; j <= 40; j++) begin
            if (tick && first < 0) first = j;
            cyc();
        end
        chk("mid.first_tick_after_restart", first, 8);

        // enable dropped while busy: rx_en held until busy falls
        enable = 0;
        cyc();
        chk("en.hold_busy", rx_en, 1);
        fsm_busy = 0;
        cyc();
        chk("en.drop_after_busy", rx_en, 0);

        idle_inputs();
        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Controller that sequences the UART receive datapath: the bit-level receive FSM, its SIPO shift register and the baud timing. It gates the FSM enable and generates the mid-bit `tick` from the FSM's `restart_counter` request. Received bytes go into a small first-word-fall-through FIFO read over a valid/ready handshake. It also keeps framing-error and overrun status for the host.

## Interface
- `CLKS_PER_BIT`, default 868: clk cycles per UART bit; must be ≥4 and even.
- `FIFO_DEPTH`, default 8: RX FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock.
- `arst_n`  in  1  reset; synchronous, active-low.
- `enable`  in  1  host receive enable.
- `fsm_busy`  in  1  FSM busy.
- `fsm_done`  in  1  FSM frame-complete pulse.
- `fsm_err`  in  1  FSM false-start or framing-error pulse.
- `fsm_restart`  in  1  FSM restart_counter pulse.
- `rx_byte`  in  8  SIPO parallel output; valid in the cycle `fsm_done`=1.
- `rx_en`  out  1  enable to FSM.
- `tick`  out  1  mid-bit pulse to FSM.
- `rd_valid`  out  1  FIFO not empty.
- `rd_data`  out  8  FIFO head byte.
- `rd_ready`  in  1  host pop.
- `level`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `frame_err_cnt`  out  8  saturating error count.
- `overrun`  out  1  sticky; a byte was dropped.
- `clr_status`  in  1  clears `frame_err_cnt` and `overrun`.

## Operation
- Enable gating:
  - `rx_en` goes to 1 one cycle after `enable`=1.
  - When `enable` drops while `fsm_busy`=1, `rx_en` stays 1 until the first cycle with `fsm_busy`=0, then drops. An in-flight frame is always completed.
- Baud state machine:
  - States: `B_IDLE`, `B_HALF`, `B_BIT`.
  - `B_IDLE`: on `fsm_restart`, clear `bcnt` and go to `B_HALF`.
  - `B_HALF`: when `bcnt`==CLKS_PER_BIT/2−1, assert `tick`, clear `bcnt` and go to `B_BIT`.
  - `B_BIT`: when `bcnt`==CLKS_PER_BIT−1, assert `tick` and clear `bcnt`.
  - Leaving `B_BIT`: in any cycle with `fsm_busy`=0 and no `tick` that cycle, return to `B_IDLE`.
  - `fsm_restart` in any state re-enters `B_HALF` with `bcnt` cleared.
  - `tick` is never asserted in `B_IDLE`.
  - `bcnt` width is $clog2(CLKS_PER_BIT).
- Capture:
  - On `fsm_done`, push `rx_byte`.
  - If the FIFO is full with no pop that cycle, drop the byte and set `overrun`.
  - If the FIFO is full and a pop occurs the same cycle, the push succeeds and `level` is unchanged.
- FIFO:
  - FWFT: `rd_data` is the head whenever `rd_valid`=1.
  - Pop occurs on `rd_valid && rd_ready`.
  - `rd_ready` while empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Status:
  - `fsm_err` increments `frame_err_cnt`, which saturates at 255.
  - `clr_status` in the same cycle as `fsm_err` gives count=1.
  - `clr_status` in the same cycle as an overrun drop leaves `overrun`=1.
- Reset:
  - All state and outputs go to 0, the FIFO empties and the baud FSM goes to `B_IDLE`.
  - Reset mid-frame discards the frame with no status update.

## Timing
- `tick` for the start bit fires exactly CLKS_PER_BIT/2 cycles after the `fsm_restart` cycle. Each later `tick` follows the previous one by CLKS_PER_BIT cycles.
- `tick` is a single-cycle pulse decoded from registered state; there is no combinational path from inputs.
- `fsm_done` → `rd_valid`=1 on the next cycle when the FIFO was empty.
- A pop updates `rd_data`/`rd_valid` on the next cycle.
- `level`, `frame_err_cnt` and `overrun` update one cycle after their event.
- `enable` → `rx_en` has 1-cycle latency.
- Reset values: `rx_en`, `tick`, `rd_valid` = 0; `rd_data` = 0x00; `level` = 0; `frame_err_cnt` = 0; `overrun` = 0.

## Structure
- Package `uart_pkg` holds:
  - `DATA_W`=8.
  - Baud state enum (`B_IDLE`/`B_HALF`/`B_BIT`).
  - `ERR_CNT_MAX`=255.
- Sub-module `uart_rx_fifo` (parameterised FWFT FIFO with push/pop/full/empty/level) is instantiated once.
- The baud FSM, enable gating and status logic live in `uart_rx_ctrl`.

## Test plan
CLKS_PER_BIT=16, FIFO_DEPTH=4.
- Baud timing: `fsm_restart` at cycle 0 with `fsm_busy` held 1 → `tick` at cycles 8, 24, 40, …, 152 only. Drop `fsm_busy` at 155 → no further `tick`.
- Capture: `fsm_done` with `rx_byte`=0xA5, then 0x3C → `rd_valid`=1 with `rd_data`=0xA5. Pop → 0x3C. Pop → `rd_valid`=0, `level`=0.
- Overrun: five `fsm_done` pulses (0x01..0x05) with no reads → `level`=4, `overrun`=1. Reads return 0x01..0x04.
- Full with simultaneous pop: FIFO full and `fsm_done`+`rd_ready` in the same cycle → `overrun`=0, `level`=4, and the new byte is at the tail.
- Errors: 260 `fsm_err` pulses → `frame_err_cnt`=255. `clr_status` together with `fsm_err` → count=1.
- Enable and reset:
  - `enable` deasserted mid-frame → `rx_en` drops the cycle after `fsm_busy` falls.
  - `arst_n`=0 mid-frame for one cycle → all outputs 0 and `tick` silent until the next `fsm_restart`.
